// File: rtl/button_event_scheduler.sv
// rtl/button_event_scheduler.sv - press/hold event arbiter feeding a small event FIFO
// Define BTN_AUTOREPEAT_EN to add per-button hold counters and long/repeat events.

module button_event_scheduler #(
  parameter int NUM_BTN      = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int HOLD_TICKS   = 100,
  parameter int REPEAT_TICKS = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick,
  input  logic [NUM_BTN-1:0]         btn_lvl,
  input  logic                       evt_ready,
  input  logic                       ovf_clr,
  output logic                       evt_valid,
  output logic [$clog2(NUM_BTN)-1:0] evt_id,
  output logic                       evt_long,
  output logic                       overflow
);

  localparam int IDW = $clog2(NUM_BTN);
  localparam int PW  = $clog2(FIFO_DEPTH);

  logic [NUM_BTN-1:0] r_prev;
  logic [NUM_BTN-1:0] r_pend;
  logic [IDW-1:0]     r_rr;
  logic [IDW-1:0]     r_mem_id [FIFO_DEPTH];
  logic [PW-1:0]      r_wr;
  logic [PW-1:0]      r_rd;
  logic [PW:0]        r_count;
  logic               r_ovf;

  logic [NUM_BTN-1:0] w_rise;
  logic [NUM_BTN-1:0] w_new;
  logic [NUM_BTN-1:0] w_new_long;
  logic [NUM_BTN-1:0] w_drop;
  logic [NUM_BTN-1:0] w_grant_mask;
  logic               w_pop;
  logic               w_can_push;
  logic               w_grant_vld;
  logic [IDW-1:0]     w_grant_id;

  assign w_rise     = btn_lvl & ~r_prev;
  assign w_new      = w_rise | w_new_long;
  assign w_drop     = w_new & r_pend;
  assign evt_valid  = (r_count != '0);
  assign evt_id     = evt_valid ? r_mem_id[r_rd] : '0;
  assign overflow   = r_ovf;
  assign w_pop      = evt_valid && evt_ready;
  // A full queue still accepts a push when the head leaves on the same edge.
  assign w_can_push = (r_count != (PW+1)'(FIFO_DEPTH)) || w_pop;

  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    for (int k = 0; k < NUM_BTN; k++) begin
      if (!w_grant_vld && r_pend[(int'(r_rr) + k) % NUM_BTN]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = IDW'((int'(r_rr) + k) % NUM_BTN);
      end
    end
    if (!w_can_push) begin
      w_grant_vld = 1'b0;
    end
  end

  assign w_grant_mask = w_grant_vld ? (NUM_BTN'(1) << w_grant_id) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev  <= '0;
      r_pend  <= '0;
      r_rr    <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_id[i] <= '0;
      end
    end else begin
      r_prev <= btn_lvl;
      r_pend <= (r_pend & ~w_grant_mask) | (w_new & ~r_pend);
      if (|w_drop) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
      if (w_grant_vld) begin
        r_mem_id[r_wr] <= w_grant_id;
        r_wr           <= r_wr + PW'(1);
        r_rr           <= (w_grant_id == IDW'(NUM_BTN - 1)) ? '0 : w_grant_id + IDW'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + PW'(1);
      end
      case ({w_grant_vld, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [7:0] HOLD_T = 8'(HOLD_TICKS);
  localparam logic [7:0] TOP_T  = 8'(HOLD_TICKS + REPEAT_TICKS);

  logic [7:0]         r_hold [NUM_BTN];
  logic [NUM_BTN-1:0] r_long;
  logic               r_mem_long [FIFO_DEPTH];

  always_comb begin
    w_new_long = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      w_new_long[i] = tick && btn_lvl[i] &&
                      ((r_hold[i] + 8'd1 == HOLD_T) || (r_hold[i] + 8'd1 == TOP_T));
    end
  end

  // Reaching the repeat point reloads to HOLD_T so the counter never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_long <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        r_hold[i] <= 8'd0;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_long[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (!btn_lvl[i]) begin
          r_hold[i] <= 8'd0;
        end else if (tick) begin
          r_hold[i] <= (r_hold[i] + 8'd1 == TOP_T) ? HOLD_T : r_hold[i] + 8'd1;
        end
        if (w_new[i] && !r_pend[i]) begin
          r_long[i] <= !w_rise[i];
        end
      end
      if (w_grant_vld) begin
        r_mem_long[r_wr] <= r_long[w_grant_id];
      end
    end
  end

  assign evt_long = evt_valid && r_mem_long[r_rd];
`else
  logic w_unused_cfg;
  assign w_new_long   = '0;
  assign evt_long     = 1'b0;
  assign w_unused_cfg = tick ^ (HOLD_TICKS > 0) ^ (REPEAT_TICKS > 0);
`endif

endmodule
